mix_columns_iter: RTL and testbench

Iterative, parametrised AES/Rijndael MixColumns engine with both forward and inverse modes. It processes `COLS_PER_CYCLE` 32-bit state columns per clock behind valid/ready handshakes on input and output. It replaces the combinational `MixColumn` in area-constrained round datapaths, and it adds the decryption direction and support for 192/256-bit Rijndael block widths.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/mix_single_column.sv | 35 +++
 rtl/mix_columns_iter.sv | 118 +++++++++++
 tb/tb_mix_columns_iter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - GF(2^8) helpers, FSM state type and legal widths for the MixColumns engine.
package aes_pkg;

   localparam int WIDTH_128 = 128;
   localparam int WIDTH_192 = 192;
   localparam int WIDTH_256 = 256;
   localparam int COL_BITS  = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Constants outside {2,3,9,b,d,e} fall through as multiply-by-one.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      logic [7:0] p;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (k)
         4'h2:    p = x2;
         4'h3:    p = x2 ^ a;
         4'h9:    p = x8 ^ a;
         4'hb:    p = x8 ^ x2 ^ a;
         4'hd:    p = x8 ^ x4 ^ a;
         4'he:    p = x8 ^ x4 ^ x2;
         default: p = a;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/mix_single_column.sv
// rtl/mix_single_column.sv - Combinational forward/inverse MixColumns on one 32-bit column.
module mix_single_column
   import aes_pkg::*;
(
   input  logic [31:0] column,
   input  logic        inv,
   output logic [31:0] mixed
);

   logic [7:0] a0;
   logic [7:0] a1;
   logic [7:0] a2;
   logic [7:0] a3;

   assign a0 = column[31:24];
   assign a1 = column[23:16];
   assign a2 = column[15:8];
   assign a3 = column[7:0];

   always_comb begin
      mixed = '0;
      if (inv) begin
         mixed[31:24] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
         mixed[23:16] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
         mixed[15:8]  = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
         mixed[7:0]   = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
      end else begin
         mixed[31:24] = gf_mul(a0, 4'h2) ^ gf_mul(a1, 4'h3) ^ a2 ^ a3;
         mixed[23:16] = a0 ^ gf_mul(a1, 4'h2) ^ gf_mul(a2, 4'h3) ^ a3;
         mixed[15:8]  = a0 ^ a1 ^ gf_mul(a2, 4'h2) ^ gf_mul(a3, 4'h3);
         mixed[7:0]   = gf_mul(a0, 4'h3) ^ a1 ^ a2 ^ gf_mul(a3, 4'h2);
      end
   end

endmodule

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - Iterative MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per clock.
module mix_columns_iter
   import aes_pkg::*;
#(
   parameter int WIDTH          = 128,
   parameter int COLS_PER_CYCLE = 1
)
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic             inv_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int NC    = WIDTH / COL_BITS;
   localparam int BEATS = NC / COLS_PER_CYCLE;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W = $clog2(NC);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   if (WIDTH != WIDTH_128 && WIDTH != WIDTH_192 && WIDTH != WIDTH_256) begin : g_bad_width
      $error("mix_columns_iter: WIDTH must be 128, 192 or 256");
   end
   if (COLS_PER_CYCLE < 1 || (NC % COLS_PER_CYCLE) != 0) begin : g_bad_cols
      $error("mix_columns_iter: COLS_PER_CYCLE must divide WIDTH/32");
   end

   state_e              state_q;
   state_e              state_d;
   logic [CNT_W-1:0]    beat_q;
   logic [WIDTH-1:0]    src_q;
   logic                inv_q;
   logic [31:0]         res_q    [NC];
   logic [31:0]         src_cols [NC];
   logic [IDX_W-1:0]    col_idx  [COLS_PER_CYCLE];
   logic [31:0]         col_sel  [COLS_PER_CYCLE];
   logic [31:0]         col_mix  [COLS_PER_CYCLE];
   logic                load;
   logic                step;

   // Column 0 sits in the most significant word, matching FIPS-197 byte order.
   for (genvar c = 0; c < NC; c++) begin : g_cols
      assign src_cols[c]                  = src_q[WIDTH-1-32*c -: 32];
      assign data_o[WIDTH-1-32*c -: 32]   = res_q[c];
   end

   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
      assign col_idx[k] = IDX_W'(beat_q) * IDX_W'(COLS_PER_CYCLE) + IDX_W'(k);
      assign col_sel[k] = src_cols[col_idx[k]];

      mix_single_column u_mix (
         .column (col_sel[k]),
         .inv    (inv_q),
         .mixed  (col_mix[k])
      );
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      ready_o = 1'b0;
      valid_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               load    = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            step = 1'b1;
            if (beat_q == LAST_BEAT) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            valid_o = 1'b1;
            if (ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         src_q   <= '0;
         inv_q   <= 1'b0;
         for (int c = 0; c < NC; c++) begin
            res_q[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (load) begin
            src_q  <= data_i;
            inv_q  <= inv_i;
            beat_q <= '0;
         end
         if (step) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
               res_q[col_idx[k]] <= col_mix[k];
            end
            beat_q <= beat_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - Self-checking bench for mix_columns_iter against a GF(2^8) matrix model.
module tb_mix_columns_iter;

   localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
   localparam logic [127:0] COL_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [255:0] W_IN     = {4{64'hd4d4d4d5_2d26314c}};
   localparam logic [255:0] W_OUT    = {4{64'hd5d5d7d6_4d7ebdf8}};

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic         v_i, r_o, inv, v_o, r_i;
   logic [127:0] d_i, d_o;
   logic         v4_i, r4_o, inv4, v4_o, r4_i;
   logic [127:0] d4_i, d4_o;
   logic         v8_i, r8_o, inv8, v8_o, r8_i;
   logic [255:0] d8_i, d8_o;

   mix_columns_iter u_dut (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v_i), .ready_o(r_o), .data_i(d_i),
      .inv_i(inv), .valid_o(v_o), .ready_i(r_i), .data_o(d_o)
   );
   mix_columns_iter #(.WIDTH(128), .COLS_PER_CYCLE(4)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v4_i), .ready_o(r4_o), .data_i(d4_i),
      .inv_i(inv4), .valid_o(v4_o), .ready_i(r4_i), .data_o(d4_o)
   );
   mix_columns_iter #(.WIDTH(256), .COLS_PER_CYCLE(2)) u_dut8 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v8_i), .ready_o(r8_o), .data_i(d8_i),
      .inv_i(inv8), .valid_o(v8_o), .ready_i(r8_i), .data_o(d8_o)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Carry-less polynomial product, then long division by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++) if (b[i]) prod ^= 15'(a) << i;
      for (int i = 14; i >= 8; i--) if (prod[i]) prod ^= 15'h11b << (i - 8);
      return prod[7:0];
   endfunction

   function automatic logic [255:0] mix_state(input logic [255:0] s, input int w, input bit iv);
      logic [7:0]  coef [4];
      logic [7:0]  a    [4];
      logic [7:0]  b;
      logic [31:0] col;
      logic [255:0] r;
      r = '0;
      if (iv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < w / 32; c++) begin
         col = s[w-1-32*c -: 32];
         for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
         for (int rr = 0; rr < 4; rr++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b ^= gmul(a[j], coef[(j - rr + 4) % 4]);
            r[w-1-32*c-8*rr -: 8] = b;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] model128(input logic [127:0] d, input bit iv);
      logic [255:0] t;
      t = mix_state({128'b0, d}, 128, iv);
      return t[127:0];
   endfunction

   // Scoreboard for the default instance: every post-reset cycle checks ready, valid timing and data.
   logic [127:0] exp_q[$];
   int           cyc = 0;
   int           due = 0;
   bit           mon_en = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (!rst_n) begin
            exp_q.delete();
         end else begin
            check("mon_ready", r_o, exp_q.size() == 0);
            check("mon_valid", v_o, exp_q.size() > 0 && cyc >= due);
            if (v_o && exp_q.size() > 0) check("mon_data", d_o, exp_q[0]);
            if (v_o && r_i && exp_q.size() > 0) void'(exp_q.pop_front());
            if (v_i && r_o) begin
               exp_q.push_back(model128(d_i, inv));
               due = cyc + 5;
            end
         end
      end
      cyc++;
   end

   task automatic send(input logic [127:0] d, input bit iv);
      bit ok;
      int n;
      d_i = d;
      inv = iv;
      v_i = 1'b1;
      n   = 0;
      ok  = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = r_o;
         @(posedge clk);
         #1;
         n++;
      end
      v_i = 1'b0;
      inv = 1'($urandom);
      if (!ok) timeout("send");
   endtask

   task automatic wait_done(output logic [127:0] got, input bit rand_ready);
      bit hs;
      int n;
      hs  = 0;
      n   = 0;
      got = '0;
      while (!hs && n < 200) begin
         r_i = rand_ready ? 1'($urandom) : 1'b1;
         @(negedge clk);
         if (v_o && r_i) begin
            hs  = 1;
            got = d_o;
         end
         @(posedge clk);
         #1;
         n++;
      end
      if (!hs) timeout("wait_done");
   endtask

   task automatic run4(input logic [127:0] d, input bit iv, input logic [127:0] lit, input bit use_lit);
      int n;
      d4_i = d; inv4 = iv; v4_i = 1'b1; r4_i = 1'b1;
      @(negedge clk);
      check("c4_ready", r4_o, 1);
      @(posedge clk); #1;
      v4_i = 1'b0; inv4 = ~iv;
      n = 0;
      do begin @(negedge clk); n++; end while (!v4_o && n < 50);
      check("c4_latency", n, 2);
      check("c4_data", d4_o, model128(d, iv));
      if (use_lit) check("c4_known", d4_o, lit);
      @(posedge clk); #1;
      @(negedge clk);
      check("c4_valid_drop", v4_o, 0);
      @(posedge clk); #1;
   endtask

   task automatic run8(input logic [255:0] d, input bit iv, input logic [255:0] lit, input bit use_lit);
      int n;
      d8_i = d; inv8 = iv; v8_i = 1'b1; r8_i = 1'b1;
      @(negedge clk);
      check("w256_ready", r8_o, 1);
      @(posedge clk); #1;
      v8_i = 1'b0; inv8 = ~iv;
      n = 0;
      do begin @(negedge clk); n++; end while (!v8_o && n < 50);
      check("w256_latency", n, 5);
      check("w256_data", d8_o, mix_state(d, 256, iv));
      if (use_lit) check("w256_known", d8_o, lit);
      @(posedge clk); #1;
      @(negedge clk);
      check("w256_valid_drop", v8_o, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      logic [127:0] got, held, x;
      int n;
      rst_n = 1'b0;
      v_i = 0; inv = 0; r_i = 0; d_i = '0;
      v4_i = 0; inv4 = 0; r4_i = 0; d4_i = '0;
      v8_i = 0; inv8 = 0; r8_i = 0; d8_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", r_o, 1);
      check("rst_valid", v_o, 0);
      check("rst_data", d_o, 0);
      check("rst_ready4", r4_o, 1);
      check("rst_valid4", v4_o, 0);
      check("rst_data8", d8_o, 0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1;

      check("model_fips_fwd", model128(FIPS_IN, 0), FIPS_OUT);
      check("model_fips_inv", model128(FIPS_OUT, 1), FIPS_IN);
      check("model_cols", model128(COL_IN, 0), COL_OUT);
      check("model_w256", mix_state(W_IN, 256, 0), W_OUT);

      r_i = 1'b1;
      send(FIPS_IN, 0);
      wait_done(got, 0);
      check("fips_fwd", got, FIPS_OUT);
      @(negedge clk);
      check("fips_valid_pulse", v_o, 0);
      @(posedge clk); #1;

      send(FIPS_OUT, 1);
      wait_done(got, 0);
      check("fips_inv", got, FIPS_IN);

      // Backpressure: hold ready_i low, inject an ignored valid_i pulse.
      r_i = 1'b0;
      x = {$urandom, $urandom, $urandom, $urandom};
      send(x, 0);
      n = 0;
      do begin @(negedge clk); n++; end while (!v_o && n < 50);
      if (!v_o) timeout("bp_valid_rise");
      held = d_o;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         v_i = (i == 3);
         d_i = ~x;
         @(negedge clk);
         check("bp_valid", v_o, 1);
         check("bp_ready", r_o, 0);
         check("bp_hold", d_o, held);
      end
      @(posedge clk); #1;
      v_i = 1'b0;
      wait_done(got, 0);
      check("bp_result", got, model128(x, 0));
      send(~x, 1);
      wait_done(got, 0);
      check("bp_next", got, model128(~x, 1));

      // Reset asserted while beat 2 is on the way.
      send(FIPS_IN, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_valid", v_o, 0);
      check("midrst_data", d_o, 0);
      check("midrst_ready", r_o, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(COL_IN, 0);
      wait_done(got, 0);
      check("midrst_next", got, COL_OUT);

      for (int t = 0; t < 40; t++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         x = {$urandom, $urandom, $urandom, $urandom};
         send(x, 1'($urandom));
         wait_done(got, 1);
      end
      r_i = 1'b1;

      run4(COL_IN, 0, COL_OUT, 1);
      run4(FIPS_OUT, 1, FIPS_IN, 1);
      for (int t = 0; t < 10; t++) run4({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), '0, 0);

      run8(W_IN, 0, W_OUT, 1);
      run8(W_OUT, 1, W_IN, 1);
      for (int t = 0; t < 10; t++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         run8({x, ~x ^ 128'($urandom)}, 1'($urandom), '0, 0);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
